// File: rtl/nes_pad_pkg.sv
// nes_pad_pkg: shared types and constants for the NES gamepad reader.
//   pad_state_t  - frame sequencer states
//   BTN_*        - bit positions of each button inside the keycode byte
//   KEYCODE_W    - keycode width
package nes_pad_pkg;

  localparam int KEYCODE_W = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } pad_state_t;

endpackage

// File: rtl/pad_sync_2ff.sv
// pad_sync_2ff: generic two-flop synchronizer with a configurable reset value.
//   clk   - destination clock
//   reset - synchronous reset, active high; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output (two cycles of latency)
module pad_sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls a NES gamepad (4021 shift register) and publishes a
// keycode byte per frame.
//   clk, reset     - clock, synchronous active-high reset
//   enable         - permits new frames to start
//   poll_req       - single-cycle frame request (ORed with the poll timer
//                    when AUTO_POLL=1)
//   pad_data_n     - asynchronous serial data from the pad, low = pressed
//   pad_latch      - latch strobe to the pad (registered)
//   pad_clk        - shift clock to the pad (registered)
//   keycode        - button state, 1 = pressed, see BTN_* in nes_pad_pkg
//   keycode_valid  - one-cycle pulse when keycode updates
//   busy           - high while a frame is in progress
// Build option: define PAD_DEBOUNCE_EN to publish a frame only when it
// matches the previous frame's shadow value.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int LATCH_CYCLES    = 600,
  parameter int HALF_BIT_CYCLES = 300,
  parameter int POLL_PERIOD     = 833333,
  parameter int AUTO_POLL       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 poll_req,
  input  logic                 pad_data_n,
  output logic                 pad_latch,
  output logic                 pad_clk,
  output logic [KEYCODE_W-1:0] keycode,
  output logic                 keycode_valid,
  output logic                 busy
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMR_W   = $clog2(POLL_PERIOD + 1);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_BIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);

  pad_state_t           state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic [KEYCODE_W-1:0] shadow, shadow_next;
  logic [TMR_W-1:0]     timer;
  logic                 data_n_sync;
  logic                 sample;
  logic                 timer_hit;
  logic                 start;
  logic                 frame_done;
  logic                 publish;

  pad_sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_data_n),
    .q     (data_n_sync)
  );

  assign sample = ~data_n_sync;

  // Free-running poll timer; hits arriving while a frame runs are dropped
  // because start is only honoured in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (timer == TMR_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign timer_hit = (AUTO_POLL != 0) && (timer == TMR_LAST);
  assign start     = enable && (poll_req || timer_hit);

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + 1'b1;
    bit_idx_next = bit_idx;
    shadow_next  = shadow;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_next   = SHIFT_LO;
          cnt_next     = '0;
          bit_idx_next = '0;
        end
      end
      SHIFT_LO: begin
        if (cnt == HALF_LAST) begin
          shadow_next[bit_idx] = sample;
          state_next           = SHIFT_HI;
          cnt_next             = '0;
        end
      end
      SHIFT_HI: begin
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = DONE;
            frame_done = 1'b1;
          end else begin
            state_next = SHIFT_LO;
          end
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

`ifdef PAD_DEBOUNCE_EN
  logic [KEYCODE_W-1:0] history;

  always_ff @(posedge clk) begin
    if (reset) begin
      history <= '0;
    end else if (frame_done) begin
      history <= shadow;
    end
  end

  assign publish = frame_done && (shadow == history);
`else
  assign publish = frame_done;
`endif

  // Outputs are decoded from state_next and registered so they line up with
  // the state they describe and cannot glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shadow        <= '0;
      pad_latch     <= 1'b0;
      pad_clk       <= 1'b0;
      keycode       <= '0;
      keycode_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      bit_idx       <= bit_idx_next;
      shadow        <= shadow_next;
      pad_latch     <= (state_next == LATCH);
      pad_clk       <= (state_next == SHIFT_HI);
      busy          <= (state_next == LATCH) || (state_next == SHIFT_LO) ||
                       (state_next == SHIFT_HI);
      keycode_valid <= publish;
      if (publish) begin
        keycode <= shadow;
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: self-checking bench for nes_pad_reader.
// u_dut uses manual polling; u_dut_auto uses the poll timer (period 100).
// Both drive a behavioural 4021 pad model.
module tb_nes_pad_reader;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // manual-poll instance
  logic       reset_a = 1'b1, enable_a = 1'b0, poll_req_a = 1'b0;
  logic       pad_data_n_a, pad_latch_a, pad_clk_a, keycode_valid_a, busy_a;
  logic [7:0] keycode_a;

  // auto-poll instance
  logic       reset_b = 1'b1, enable_b = 1'b0;
  logic       pad_data_n_b, pad_latch_b, pad_clk_b, keycode_valid_b, busy_b;
  logic [7:0] keycode_b;

  nes_pad_reader #(
    .LATCH_CYCLES    (4),
    .HALF_BIT_CYCLES (2),
    .POLL_PERIOD     (1000),
    .AUTO_POLL       (0)
  ) u_dut (
    .clk           (clk),
    .reset         (reset_a),
    .enable        (enable_a),
    .poll_req      (poll_req_a),
    .pad_data_n    (pad_data_n_a),
    .pad_latch     (pad_latch_a),
    .pad_clk       (pad_clk_a),
    .keycode       (keycode_a),
    .keycode_valid (keycode_valid_a),
    .busy          (busy_a)
  );

  nes_pad_reader #(
    .LATCH_CYCLES    (4),
    .HALF_BIT_CYCLES (2),
    .POLL_PERIOD     (100),
    .AUTO_POLL       (1)
  ) u_dut_auto (
    .clk           (clk),
    .reset         (reset_b),
    .enable        (enable_b),
    .poll_req      (1'b0),
    .pad_data_n    (pad_data_n_b),
    .pad_latch     (pad_latch_b),
    .pad_clk       (pad_clk_b),
    .keycode       (keycode_b),
    .keycode_valid (keycode_valid_b),
    .busy          (busy_b)
  );

  // 4021 model: latch loads, output shows bit 0 (A); each rising pad_clk
  // advances one bit. Past bit 7 the line idles high.
  logic [7:0] pad_bits_a = 8'h00;
  logic [7:0] pad_bits_b = 8'h5A;
  logic [3:0] pidx_a = 4'd8;
  logic [3:0] pidx_b = 4'd8;

  always @(posedge pad_latch_a or posedge pad_clk_a)
    if (pad_latch_a) pidx_a <= 4'd0;
    else if (pidx_a != 4'd8) pidx_a <= pidx_a + 4'd1;

  always @(posedge pad_latch_b or posedge pad_clk_b)
    if (pad_latch_b) pidx_b <= 4'd0;
    else if (pidx_b != 4'd8) pidx_b <= pidx_b + 4'd1;

  assign pad_data_n_a = (pidx_a < 4'd8) ? ~pad_bits_a[pidx_a[2:0]] : 1'b1;
  assign pad_data_n_b = (pidx_b < 4'd8) ? ~pad_bits_b[pidx_b[2:0]] : 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard / monitor for the manual instance
  logic [7:0] exp_q[$];
  logic [7:0] last_pub = 8'h00;
`ifdef PAD_DEBOUNCE_EN
  logic [7:0] hist_a = 8'h00;
`endif
  int   start_cyc_a = 0, latch_cnt_a = 0, pulses_a = 0, overlap_a = 0;
  int   valid_cnt_a = 0, frames_a = 0;
  logic busy_prev_a = 1'b0, pclk_prev_a = 1'b0;

  always @(negedge clk) begin
    if (busy_a && !busy_prev_a) begin
      start_cyc_a = cyc;
      latch_cnt_a = 0;
      pulses_a    = 0;
      frames_a++;
    end
    if (pad_latch_a) latch_cnt_a++;
    if (pad_clk_a && !pclk_prev_a) pulses_a++;
    if (pad_latch_a && pad_clk_a) overlap_a++;
    if (keycode_valid_a) begin
      valid_cnt_a++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check_eq("keycode", {24'd0, keycode_a}, {24'd0, exp_q.pop_front()});
      end
      check_eq("valid_latency", cyc - start_cyc_a, 32'd36);
      check_eq("latch_cycles", latch_cnt_a, 32'd4);
      check_eq("clk_pulses", pulses_a, 32'd8);
      check_eq("latch_clk_overlap", overlap_a, 32'd0);
    end
    busy_prev_a = busy_a;
    pclk_prev_a = pad_clk_a;
  end

  // monitor for the auto instance
  int   valid_cnt_b = 0, frames_b = 0, last_valid_b = -1;
  logic busy_prev_b = 1'b0;

  always @(negedge clk) begin
    if (busy_b && !busy_prev_b) frames_b++;
    if (keycode_valid_b) begin
      valid_cnt_b++;
      check_eq("auto_keycode", {24'd0, keycode_b}, 32'h5A);
      if (last_valid_b >= 0) check_eq("auto_period", cyc - last_valid_b, 32'd100);
      last_valid_b = cyc;
    end
    busy_prev_b = busy_b;
  end

  task automatic pulse_poll();
    @(posedge clk); #1 poll_req_a = 1'b1;
    @(posedge clk); #1 poll_req_a = 1'b0;
  endtask

  // mode 0: plain frame, 1: re-pulse poll_req at start+10,
  // 2: drop enable at start+15 then confirm no new frame starts
  task automatic do_frame(input logic [7:0] bits, input int mode);
    logic pub;
    int   v0, f0;
    pad_bits_a = bits;
`ifdef PAD_DEBOUNCE_EN
    pub    = (bits == hist_a);
    hist_a = bits;
`else
    pub = 1'b1;
`endif
    if (pub) begin
      exp_q.push_back(bits);
      last_pub = bits;
    end
    v0 = valid_cnt_a;
    pulse_poll();
    if (mode == 1) begin
      repeat (10) @(posedge clk);
      #1 check_eq("busy_mid_frame", {31'd0, busy_a}, 32'd1);
      poll_req_a = 1'b1;
      @(posedge clk); #1 poll_req_a = 1'b0;
    end else if (mode == 2) begin
      repeat (15) @(posedge clk);
      #1 enable_a = 1'b0;
    end
    repeat (45) @(posedge clk);
    #1;
    check_eq("valid_count", valid_cnt_a - v0, pub ? 32'd1 : 32'd0);
    check_eq("keycode_hold", {24'd0, keycode_a}, {24'd0, last_pub});
    check_eq("busy_after_frame", {31'd0, busy_a}, 32'd0);
    if (mode == 2) begin
      f0 = frames_a;
      pulse_poll();
      repeat (45) @(posedge clk);
      #1 check_eq("no_frame_when_disabled", frames_a - f0, 32'd0);
      enable_a = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0, f0, fb;
    bit found;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_pad_latch", {31'd0, pad_latch_a}, 32'd0);
    check_eq("reset_pad_clk", {31'd0, pad_clk_a}, 32'd0);
    check_eq("reset_keycode", {24'd0, keycode_a}, 32'd0);
    check_eq("reset_valid", {31'd0, keycode_valid_a}, 32'd0);
    check_eq("reset_busy", {31'd0, busy_a}, 32'd0);
    reset_a  = 1'b0;
    reset_b  = 1'b0;
    enable_a = 1'b1;
    enable_b = 1'b1;

    do_frame(8'h09, 0);  // A + Start
    do_frame(8'h80, 0);  // Right only
    do_frame(8'h00, 0);  // nothing pressed
    do_frame(8'h3C, 1);  // ignored re-poll mid-frame

    // reset in the middle of a frame
    pad_bits_a = 8'h55;
    v0 = valid_cnt_a;
    pulse_poll();
    repeat (20) @(posedge clk);
    #1 reset_a = 1'b1;
    @(posedge clk); #1;
    check_eq("midreset_pad_latch", {31'd0, pad_latch_a}, 32'd0);
    check_eq("midreset_pad_clk", {31'd0, pad_clk_a}, 32'd0);
    check_eq("midreset_keycode", {24'd0, keycode_a}, 32'd0);
    check_eq("midreset_valid", {31'd0, keycode_valid_a}, 32'd0);
    check_eq("midreset_busy", {31'd0, busy_a}, 32'd0);
    reset_a  = 1'b0;
    last_pub = 8'h00;
`ifdef PAD_DEBOUNCE_EN
    hist_a = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1 check_eq("midreset_no_valid", valid_cnt_a - v0, 32'd0);
    do_frame(8'h42, 0);

    do_frame(8'h01, 0);
    do_frame(8'h03, 0);
    do_frame(8'h03, 0);
    do_frame(8'h81, 2);  // enable dropped mid-frame

    // auto poll: drop enable at cycle 15 of a frame
    f0 = frames_b;
    found = 1'b0;
    for (int i = 0; i < 250 && !found; i++) begin
      @(negedge clk);
      if (frames_b != f0) found = 1'b1;
    end
    check_eq("auto_frame_started", {31'd0, found}, 32'd1);
    repeat (15) @(posedge clk);
    #1 enable_b = 1'b0;
    v0 = valid_cnt_b;
    fb = frames_b;
    repeat (300) @(posedge clk);
    #1;
    check_eq("auto_drop_finishes_frame", valid_cnt_b - v0, 32'd1);
    check_eq("auto_no_new_frames", frames_b - fb, 32'd0);
    check_eq("auto_busy_idle", {31'd0, busy_b}, 32'd0);
    check_eq("auto_enough_frames", {31'd0, valid_cnt_b >= 3}, 32'd1);
    check_eq("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
